// File: rtl/mipsm_ctrl.sv
// Multicycle MIPS control sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback steps and decodes enables/mux selects from its state.
module mipsm_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pcwrite,
  output logic       o_iord,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [2:0] o_alucom,
  output logic [1:0] o_pcsrc,
  output logic       o_retire,
  output logic [3:0] o_state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_REXE   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXE   = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_REG  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  logic [3:0] r_state;
  logic       r_is_store;

  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_alucom;
  logic [1:0] w_pcsrc;
  logic       w_retire;

  // State register; load/store direction is captured in DECODE for the MEMADR split.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_store <= (i_opcode == OP_SW);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_alucom   = ALU_ADD;
    w_pcsrc    = 2'b00;
    w_retire   = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = i_mem_ready;
        w_pcwrite = i_mem_ready;
        if (i_mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        w_alusrcb = 2'b11;
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_ADDI:      w_next = S_IEXE;
          OP_BEQ,
          OP_BNE:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_REG: begin
            if (i_func[5:3] == 3'b100) begin
              w_next = S_REXE;
            end else begin
              w_next   = S_FETCH;
              w_retire = 1'b1;
            end
          end
          default: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = r_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord    = 1'b1;
        w_memread = 1'b1;
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (i_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_REXE: begin
        w_alusrca = 1'b1;
        w_alucom  = i_func[2:0];
        w_next    = S_RWB;
      end
      S_RWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_IEXE: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_alucom  = ALU_SUB;
        w_pcsrc   = 2'b01;
        w_retire  = 1'b1;
        w_pcwrite = ((i_opcode == OP_BEQ) & i_zero) | ((i_opcode == OP_BNE) & ~i_zero);
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b10;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset masks every output so no write enable coincides with rst.
  assign o_pcwrite  = w_pcwrite  & ~i_rst;
  assign o_iord     = w_iord     & ~i_rst;
  assign o_memread  = w_memread  & ~i_rst;
  assign o_memwrite = w_memwrite & ~i_rst;
  assign o_irwrite  = w_irwrite  & ~i_rst;
  assign o_regwrite = w_regwrite & ~i_rst;
  assign o_regdst   = w_regdst   & ~i_rst;
  assign o_memtoreg = w_memtoreg & ~i_rst;
  assign o_alusrca  = w_alusrca  & ~i_rst;
  assign o_alusrcb  = i_rst ? 2'b00 : w_alusrcb;
  assign o_alucom   = i_rst ? 3'b000 : w_alucom;
  assign o_pcsrc    = i_rst ? 2'b00 : w_pcsrc;
  assign o_retire   = w_retire   & ~i_rst;
  assign o_state    = i_rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_mipsm_ctrl.sv
// Directed bench for mipsm_ctrl: stimulus queues hand-computed output vectors per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_mipsm_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucom;
    logic [1:0] pcsrc;
    logic       retire;
  } outv_t;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, iord, memread, memwrite, irwrite, regwrite;
  logic       regdst, memtoreg, alusrca, retire;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucom;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  outv_t q_exp[$];
  string q_name[$];

  mipsm_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_opcode    (opcode),
    .i_func      (func),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_pcwrite   (pcwrite),
    .o_iord      (iord),
    .o_memread   (memread),
    .o_memwrite  (memwrite),
    .o_irwrite   (irwrite),
    .o_regwrite  (regwrite),
    .o_regdst    (regdst),
    .o_memtoreg  (memtoreg),
    .o_alusrca   (alusrca),
    .o_alusrcb   (alusrcb),
    .o_alucom    (alucom),
    .o_pcsrc     (pcsrc),
    .o_retire    (retire),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {pcwrite,iord,memread,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca}
  function automatic outv_t mk(input logic [3:0] st, input logic [8:0] en,
                               input logic [1:0] asb, input logic [2:0] alu,
                               input logic [1:0] pcs, input logic ret);
    outv_t v;
    v.state    = st;
    v.pcwrite  = en[8];
    v.iord     = en[7];
    v.memread  = en[6];
    v.memwrite = en[5];
    v.irwrite  = en[4];
    v.regwrite = en[3];
    v.regdst   = en[2];
    v.memtoreg = en[1];
    v.alusrca  = en[0];
    v.alusrcb  = asb;
    v.alucom   = alu;
    v.pcsrc    = pcs;
    v.retire   = ret;
    return v;
  endfunction

  outv_t E_ZERO, E_FETCH_OK, E_FETCH_ST, E_DEC, E_DEC_NOP, E_MADR, E_MRD, E_MWB;
  outv_t E_MWR_ST, E_MWR_OK, E_REXE_SUB, E_RWB, E_IEXE, E_IWB, E_BR_T, E_BR_N, E_JMP;

  // Monitor: every cycle the DUT presents a full control vector.
  outv_t m_exp, m_act;
  string m_nm;
  always @(negedge clk) begin
    if (q_exp.size() != 0) begin
      m_exp = q_exp.pop_front();
      m_nm  = q_name.pop_front();
      m_act = '{state: state, pcwrite: pcwrite, iord: iord, memread: memread,
                memwrite: memwrite, irwrite: irwrite, regwrite: regwrite,
                regdst: regdst, memtoreg: memtoreg, alusrca: alusrca,
                alusrcb: alusrcb, alucom: alucom, pcsrc: pcsrc, retire: retire};
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b", m_nm, $time, m_act, m_exp);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic mr, input logic z,
                     input logic [5:0] op, input logic [5:0] fn, input outv_t e);
    rst       = r;
    mem_ready = mr;
    zero      = z;
    opcode    = op;
    func      = fn;
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    E_ZERO     = '0;
    E_FETCH_OK = mk(4'd0,  9'b101010000, 2'b01, 3'b000, 2'b00, 1'b0);
    E_FETCH_ST = mk(4'd0,  9'b001000000, 2'b01, 3'b000, 2'b00, 1'b0);
    E_DEC      = mk(4'd1,  9'b000000000, 2'b11, 3'b000, 2'b00, 1'b0);
    E_DEC_NOP  = mk(4'd1,  9'b000000000, 2'b11, 3'b000, 2'b00, 1'b1);
    E_MADR     = mk(4'd2,  9'b000000001, 2'b10, 3'b000, 2'b00, 1'b0);
    E_MRD      = mk(4'd3,  9'b011000000, 2'b00, 3'b000, 2'b00, 1'b0);
    E_MWB      = mk(4'd4,  9'b000001010, 2'b00, 3'b000, 2'b00, 1'b1);
    E_MWR_ST   = mk(4'd5,  9'b010100000, 2'b00, 3'b000, 2'b00, 1'b0);
    E_MWR_OK   = mk(4'd5,  9'b010100000, 2'b00, 3'b000, 2'b00, 1'b1);
    E_REXE_SUB = mk(4'd6,  9'b000000001, 2'b00, 3'b010, 2'b00, 1'b0);
    E_RWB      = mk(4'd7,  9'b000001100, 2'b00, 3'b000, 2'b00, 1'b1);
    E_IEXE     = mk(4'd8,  9'b000000001, 2'b10, 3'b000, 2'b00, 1'b0);
    E_IWB      = mk(4'd9,  9'b000001000, 2'b00, 3'b000, 2'b00, 1'b1);
    E_BR_T     = mk(4'd10, 9'b100000001, 2'b00, 3'b010, 2'b01, 1'b1);
    E_BR_N     = mk(4'd10, 9'b000000001, 2'b00, 3'b010, 2'b01, 1'b1);
    E_JMP      = mk(4'd11, 9'b100000000, 2'b00, 3'b000, 2'b10, 1'b1);

    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h3f; func = 6'h00;
    @(posedge clk);
    #1;

    // Reset held two cycles, then a no-op (illegal opcode) instruction.
    cyc("rst0",      1, 1, 0, 6'h3f, 6'h00, E_ZERO);
    cyc("rst1",      1, 1, 0, 6'h3f, 6'h00, E_ZERO);
    cyc("nop_fetch", 0, 1, 0, 6'h3f, 6'h00, E_FETCH_OK);
    cyc("nop_dec",   0, 1, 0, 6'h3f, 6'h00, E_DEC_NOP);

    // LW with two fetch stalls and one read stall; mem_ready low in DECODE is ignored.
    cyc("lw_f_st0",  0, 0, 0, 6'b100011, 6'h00, E_FETCH_ST);
    cyc("lw_f_st1",  0, 0, 0, 6'b100011, 6'h00, E_FETCH_ST);
    cyc("lw_f_ok",   0, 1, 0, 6'b100011, 6'h00, E_FETCH_OK);
    cyc("lw_dec",    0, 0, 0, 6'b100011, 6'h00, E_DEC);
    cyc("lw_madr",   0, 1, 0, 6'b100011, 6'h00, E_MADR);
    cyc("lw_mrd_st", 0, 0, 0, 6'b100011, 6'h00, E_MRD);
    cyc("lw_mrd_ok", 0, 1, 0, 6'b100011, 6'h00, E_MRD);
    cyc("lw_mwb",    0, 1, 0, 6'b100011, 6'h00, E_MWB);

    // SW interrupted by reset while the write is pending.
    cyc("sw_fetch",  0, 1, 0, 6'b101011, 6'h00, E_FETCH_OK);
    cyc("sw_dec",    0, 1, 0, 6'b101011, 6'h00, E_DEC);
    cyc("sw_madr",   0, 1, 0, 6'b101011, 6'h00, E_MADR);
    cyc("sw_mwr_st", 0, 0, 0, 6'b101011, 6'h00, E_MWR_ST);
    cyc("sw_rst",    1, 0, 0, 6'b101011, 6'h00, E_ZERO);

    // R-type sub; mem_ready low in RWB must not matter.
    cyc("r_fetch",   0, 1, 0, 6'b000000, 6'b100010, E_FETCH_OK);
    cyc("r_dec",     0, 1, 0, 6'b000000, 6'b100010, E_DEC);
    cyc("r_rexe",    0, 1, 0, 6'b000000, 6'b100010, E_REXE_SUB);
    cyc("r_rwb",     0, 0, 0, 6'b000000, 6'b100010, E_RWB);

    // ADDI.
    cyc("i_fetch",   0, 1, 0, 6'b001000, 6'h00, E_FETCH_OK);
    cyc("i_dec",     0, 1, 0, 6'b001000, 6'h00, E_DEC);
    cyc("i_iexe",    0, 1, 0, 6'b001000, 6'h00, E_IEXE);
    cyc("i_iwb",     0, 1, 0, 6'b001000, 6'h00, E_IWB);

    // BEQ taken, BNE not taken, BNE taken.
    cyc("beq_fetch", 0, 1, 1, 6'b000100, 6'h00, E_FETCH_OK);
    cyc("beq_dec",   0, 1, 1, 6'b000100, 6'h00, E_DEC);
    cyc("beq_br",    0, 1, 1, 6'b000100, 6'h00, E_BR_T);
    cyc("bne1_fetch",0, 1, 1, 6'b000101, 6'h00, E_FETCH_OK);
    cyc("bne1_dec",  0, 1, 1, 6'b000101, 6'h00, E_DEC);
    cyc("bne1_br",   0, 1, 1, 6'b000101, 6'h00, E_BR_N);
    cyc("bne0_fetch",0, 1, 0, 6'b000101, 6'h00, E_FETCH_OK);
    cyc("bne0_dec",  0, 1, 0, 6'b000101, 6'h00, E_DEC);
    cyc("bne0_br",   0, 1, 0, 6'b000101, 6'h00, E_BR_T);

    // J, then an R-type with func[5:3] != 100 which is a no-op.
    cyc("j_fetch",   0, 1, 0, 6'b000010, 6'h00, E_FETCH_OK);
    cyc("j_dec",     0, 1, 0, 6'b000010, 6'h00, E_DEC);
    cyc("j_jump",    0, 1, 0, 6'b000010, 6'h00, E_JMP);
    cyc("jr_fetch",  0, 1, 0, 6'b000000, 6'b001000, E_FETCH_OK);
    cyc("jr_dec",    0, 1, 0, 6'b000000, 6'b001000, E_DEC_NOP);

    // Complete SW, then reset in FETCH with mem_ready high.
    cyc("sw2_fetch", 0, 1, 0, 6'b101011, 6'h00, E_FETCH_OK);
    cyc("sw2_dec",   0, 1, 0, 6'b101011, 6'h00, E_DEC);
    cyc("sw2_madr",  0, 1, 0, 6'b101011, 6'h00, E_MADR);
    cyc("sw2_mwr",   0, 1, 0, 6'b101011, 6'h00, E_MWR_OK);
    cyc("end_fetch", 0, 1, 0, 6'h3f, 6'h00, E_FETCH_OK);
    cyc("rst_fetch", 1, 1, 0, 6'h3f, 6'h00, E_ZERO);
    cyc("post_rst",  0, 1, 0, 6'h3f, 6'h00, E_FETCH_OK);

    @(negedge clk);
    #1;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipsm_ctrl.md
# mipsm_ctrl

Multicycle control sequencer for the MIPS datapath, so one ALU and one unified instruction/data memory port serve every instruction step. Each cycle it decodes the latched opcode/func and its own state into enables and mux selects for the PC, instruction register, register file, ALU and memory. It stalls on a memory ready handshake. It sits beside the multicycle datapath and replaces the single-cycle combinational decoder.

## Interface
- Parameters: none. Widths come from def.h: OPCODE_W=6, SEL_W=3.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  instr[31:26] from the instruction register.
- func  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag, combinational from the current ALU op.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pcwrite  out  1  PC register load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load enable.
- regwrite  out  1  register file write enable.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  write data select: 1 = memory data register, 0 = ALUOut.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- alucom  out  3  ALU operation, SEL_W encoding: `ALU_ADD = 3'b000, `ALU_SUB = 3'b010; R-type passes func[2:0].
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = {pc[31:28], instr[25:0], 2'b0}.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- state  out  4  current state encoding, for debug.

## Operation
- Outputs are decoded from the state register. Signals not listed for a state are 0; alucom defaults to ALU_ADD.
- FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
  - irwrite and pcwrite equal mem_ready.
  - Stay in FETCH while !mem_ready; go to DECODE when mem_ready.
- DECODE(1): alusrca=0, alusrcb=11, ADD; this precomputes the branch target into ALUOut. Next state:
  - LW or SW: MEMADR.
  - OP_REG with func[5:3]==3'b100: REXE.
  - ADDI: IEXE.
  - BEQ or BNE: BRANCH.
  - J: JUMP.
  - Anything else is a no-op: go to FETCH with retire=1.
- MEMADR(2): alusrca=1, alusrcb=10, ADD. Next is MEMRD for LW, MEMWR for SW.
- MEMRD(3): iord=1, memread=1. Wait for mem_ready, then go to MEMWB.
- MEMWB(4): regwrite=1, regdst=0, memtoreg=1, retire=1. Next is FETCH.
- MEMWR(5): iord=1, memwrite=1. Hold until mem_ready; in that cycle retire=1 and next is FETCH.
- REXE(6): alusrca=1, alusrcb=00, alucom=func[2:0]. Next is RWB.
- RWB(7): regwrite=1, regdst=1, memtoreg=0, retire=1. Next is FETCH.
- IEXE(8): alusrca=1, alusrcb=10, ADD. Next is IWB.
- IWB(9): regwrite=1, regdst=0, memtoreg=0, retire=1. Next is FETCH.
- BRANCH(10): alusrca=1, alusrcb=00, SUB, pcsrc=01, retire=1. Next is FETCH.
  - pcwrite = (BEQ & zero) | (BNE & !zero). It is combinational in zero.
- JUMP(11): pcwrite=1, pcsrc=10, retire=1. Next is FETCH.
- Encodings 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Write enables (pcwrite, irwrite, regwrite, memwrite) are never asserted in the same cycle as rst.

## Timing
- Reset: while rst=1, all outputs are forced to 0 and state is forced to 0. The first cycle after rst falls is FETCH, so memread=1.
- Reset mid-instruction (including a pending store): the next edge returns to FETCH. memwrite drops in the rst cycle and the partial instruction is not retired.
- Cycles per instruction with mem_ready always 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3, no-op 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Memory requests and iord are held stable throughout the stall.
- The memory handshake is level: a request is complete in the cycle memread or memwrite is high together with mem_ready. No request is issued on the cycle after completion unless the next state requests again.
- mem_ready is ignored in every other state.
- opcode and func are sampled only in DECODE, REXE (func) and BRANCH. The instruction register does not change outside FETCH.

## Test plan
- Reset and fetch: hold rst high for 2 cycles → all outputs are 0. Release with mem_ready=1 → FETCH asserts memread, irwrite, pcwrite; the next cycle state=1.
- LW with memory stalls: opcode 100011, mem_ready low 2 cycles in FETCH and 1 cycle in MEMRD → state sequence 0,0,0,1,2,3,3,4,0. MEMWB has regwrite=1 and memtoreg=1. retire pulses exactly once; the whole instruction takes 8 cycles.
- SW, then reset mid-store: opcode 101011 reaches MEMWR with mem_ready=0, then rst=1 → memwrite=0 in the rst cycle and state=0 on the next cycle. No retire pulse.
- R-type sub: opcode 000000, func 100010 → REXE has alucom=3'b010 and alusrcb=00. RWB has regdst=1. 4 cycles total.
- Branches: BEQ with zero=1 → pcwrite=1 and pcsrc=01 in BRANCH. BNE with zero=1 → pcwrite=0. Both return to FETCH after 3 cycles.
- J and illegal opcode: opcode 000010 → JUMP asserts pcwrite=1 with pcsrc=10. Opcode 111111 → DECODE then FETCH, retire=1, no write enable asserted.
